pwm_multi_channel: RTL

Parametrised N-channel PWM generator that replaces the single-channel fixed-table LED dimmer. All channels share one period counter. Each channel has its own runtime-programmable duty value. Duty and period updates are double-buffered so they take effect only at a period boundary, which keeps the outputs glitch-free. An optional per-channel ramp (fade) mode moves each active duty toward its target by a programmable step once per period. The block sits between the control logic (button, rotary encoder, LCD front-end) and the LED or other PWM pins.

---
 rtl/pwm_pkg.sv | 34 +++
 rtl/pwm_multi_channel_if.sv | 31 +++
 rtl/pwm_channel.sv | 62 ++++++
 rtl/pwm_multi_channel.sv | 79 +++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM block: default sizing, minimum period and
// the standard LED dimming periods/duty presets at a 50 MHz system clock.
package pwm_pkg;

    localparam int DEF_NUM_CH   = 8;
    localparam int DEF_CNT_W    = 23;
    localparam int MIN_PERIOD   = 2;

    localparam int CLK_HZ       = 50_000_000;
    localparam int PERIOD_25HZ  = 2_000_000;
    localparam int PERIOD_100HZ = 500_000;

    typedef enum logic [2:0] {
        DUTY_5,
        DUTY_25,
        DUTY_50,
        DUTY_75,
        DUTY_100
    } duty_preset_e;

    // Largest LED period times 100 still fits in a signed 32-bit int.
    function automatic int preset_ticks(input int period, input duty_preset_e preset);
        int pct;
        case (preset)
            DUTY_5:   pct = 5;
            DUTY_25:  pct = 25;
            DUTY_50:  pct = 50;
            DUTY_75:  pct = 75;
            default:  pct = 100;
        endcase
        return (period * pct) / 100;
    endfunction

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Control/status bundle between the front-end control logic (master) and the
// PWM generator (slave).
interface pwm_multi_channel_if #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 23,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              enable;
    logic [CNT_W-1:0]  period_in;
    logic              period_load;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_duty;
    logic              ramp_en;
    logic [CNT_W-1:0]  ramp_step;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;
    logic [NUM_CH-1:0] ramping;

    modport master (
        output enable, period_in, period_load, wr_en, wr_ch, wr_duty,
               ramp_en, ramp_step,
        input  pwm_out, period_start, ramping
    );

    modport slave (
        input  enable, period_in, period_load, wr_en, wr_ch, wr_duty,
               ramp_en, ramp_step,
        output pwm_out, period_start, ramping
    );
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: target/active duty pair, per-period ramp toward the
// target, and the registered compare against the shared period counter.
module pwm_channel #(
    parameter int CNT_W = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wrap,
    input  logic             wr_sel,
    input  logic [CNT_W-1:0] wr_duty,
    input  logic             ramp_en,
    input  logic [CNT_W-1:0] ramp_step,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm_out,
    output logic             ramping
);

    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] active_next;
    logic [CNT_W:0]   diff;
    logic [CNT_W:0]   delta;
    logic             going_up;

    // One extra bit keeps the difference and the clamped step exact.
    always_comb begin
        going_up    = active < target;
        diff        = going_up ? ({1'b0, target} - {1'b0, active})
                               : ({1'b0, active} - {1'b0, target});
        delta       = ({1'b0, ramp_step} < diff) ? {1'b0, ramp_step} : diff;
        active_next = target;
        if (ramp_en && (ramp_step != '0)) begin
            if (going_up) begin
                active_next = CNT_W'({1'b0, active} + delta);
            end else begin
                active_next = CNT_W'({1'b0, active} - delta);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target  <= '0;
            active  <= '0;
            pwm_out <= 1'b0;
            ramping <= 1'b0;
        end else begin
            if (wr_sel) begin
                target <= wr_duty;
            end
            if (!enable) begin
                active <= target;
            end else if (wrap) begin
                active <= active_next;
            end
            pwm_out <= enable && (cnt < active);
            ramping <= (active != target);
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator sharing one period counter; period and duty
// updates are double-buffered and only take effect at the period wrap.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input logic                clk,
    input logic                reset,
    pwm_multi_channel_if.slave bus
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period_shadow;
    logic [CNT_W-1:0]  period_active;
    logic              period_start;
    logic              wrap;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] pwm_bits;
    logic [NUM_CH-1:0] ramp_bits;

    assign wrap = bus.enable && (cnt == period_active - ONE);

    // Channel indices beyond NUM_CH match no select line and are dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            period_shadow <= MIN_P;
            period_active <= MIN_P;
            period_start  <= 1'b0;
        end else begin
            if (bus.period_load) begin
                period_shadow <= (bus.period_in < MIN_P) ? MIN_P : bus.period_in;
            end
            if (!bus.enable || wrap) begin
                cnt           <= '0;
                period_active <= period_shadow;
            end else begin
                cnt <= cnt + ONE;
            end
            period_start <= bus.enable && (cnt == '0);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .enable    (bus.enable),
            .wrap      (wrap),
            .wr_sel    (wr_sel[i]),
            .wr_duty   (bus.wr_duty),
            .ramp_en   (bus.ramp_en),
            .ramp_step (bus.ramp_step),
            .cnt       (cnt),
            .pwm_out   (pwm_bits[i]),
            .ramping   (ramp_bits[i])
        );
    end

    assign bus.pwm_out      = pwm_bits;
    assign bus.ramping      = ramp_bits;
    assign bus.period_start = period_start;

endmodule
